// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and the matching decoder bench.
// Holds the op codes, destination codes, opcode prefixes and the reserved NOP bytes.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_MOV  = 3'd1,
        OP_ALU  = 3'd2,
        OP_JMP  = 3'd3,
        OP_JNZ  = 3'd4,
        OP_NOP  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        DST_X0    = 3'd0,
        DST_X1    = 3'd1,
        DST_Y0    = 3'd2,
        DST_Y1    = 3'd3,
        DST_O_REG = 3'd4,
        DST_M     = 3'd5,
        DST_I     = 3'd6,
        DST_DM    = 3'd7
    } dst_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    localparam logic       PFX_LOAD = 1'b0;
    localparam logic [1:0] PFX_MOV  = 2'b10;
    localparam logic [2:0] PFX_ALU  = 3'b110;
    localparam logic [3:0] PFX_JMP  = 4'b1110;
    localparam logic [3:0] PFX_JNZ  = 4'b1111;

    localparam logic [7:0] NOP_BYTE = 8'hC8;
    localparam logic [7:0] RSV_CF   = 8'hCF;
    localparam logic [7:0] RSV_D8   = 8'hD8;
    localparam logic [7:0] RSV_DF   = 8'hDF;

    // These four bytes land in the ALU prefix space but decode as NOP.
    function automatic logic is_reserved_nop(input logic [7:0] b);
        return (b == NOP_BYTE) || (b == RSV_CF) || (b == RSV_D8) || (b == RSV_DF);
    endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Combinational field-to-byte encoder; flags requests that have no legal encoding.
module instr_encode_comb
    import instr_encoder_pkg::*;
(
    input  logic [2:0] op,
    input  logic [2:0] dst,
    input  logic [2:0] src,
    input  logic       src_pins,
    input  logic [3:0] imm,
    input  logic       alu_x,
    input  logic       alu_y,
    input  logic [2:0] alu_func,
    output logic [7:0] code,
    output logic       illegal
);

    always_comb begin
        code    = NOP_BYTE;
        illegal = 1'b0;
        case (op)
            OP_LOAD: code = {PFX_LOAD, dst, imm};
            OP_MOV: begin
                // Pin reads reuse the dst==src slot, so a true self-move is unencodable
                // except for o_reg, whose self-move byte means "o_reg <- r".
                if (src_pins) begin
                    code    = {PFX_MOV, dst, dst};
                    illegal = (dst == DST_O_REG);
                end else begin
                    code    = {PFX_MOV, dst, src};
                    illegal = (dst == src) && (dst != DST_O_REG);
                end
            end
            OP_ALU: begin
                code    = {PFX_ALU, alu_x, alu_y, alu_func};
                illegal = is_reserved_nop(code);
            end
            OP_JMP:  code = {PFX_JMP, imm};
            OP_JNZ:  code = {PFX_JNZ, imm};
            OP_NOP:  code = NOP_BYTE;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction bytes into program memory, one write per accepted request,
// with a sticky error flag and a 256-byte fill limit.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [2:0] dst,
    input  logic [2:0] src,
    input  logic       src_pins,
    input  logic [3:0] imm,
    input  logic       alu_x,
    input  logic       alu_y,
    input  logic [2:0] alu_func,
    output logic       pm_we,
    output logic [7:0] pm_addr,
    output logic [7:0] pm_data,
    output logic       err,
    output logic       full,
    output logic [8:0] count
);

    state_e     state_reg;
    logic       in_ready_reg;
    logic       pm_we_reg;
    logic [7:0] pm_addr_reg;
    logic [7:0] pm_data_reg;
    logic       err_reg;
    logic       full_reg;
    logic [8:0] count_reg;

    logic [7:0] enc_byte;
    logic       enc_illegal;
    logic       accept;

    instr_encode_comb u_encode (
        .op       (op),
        .dst      (dst),
        .src      (src),
        .src_pins (src_pins),
        .imm      (imm),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_func (alu_func),
        .code     (enc_byte),
        .illegal  (enc_illegal)
    );

    assign accept = in_valid && (state_reg == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            in_ready_reg <= 1'b0;
            pm_we_reg    <= 1'b0;
            pm_addr_reg  <= 8'd0;
            pm_data_reg  <= 8'd0;
            err_reg      <= 1'b0;
            full_reg     <= 1'b0;
            count_reg    <= 9'd0;
        end else begin
            pm_we_reg <= 1'b0;
            if (start) begin
                state_reg    <= ST_RUN;
                in_ready_reg <= 1'b1;
                pm_addr_reg  <= 8'd0;
                err_reg      <= 1'b0;
                full_reg     <= 1'b0;
                count_reg    <= 9'd0;
            end else begin
                // pm_addr moves on once the write it labels has completed; it parks at 255.
                if (pm_we_reg && (pm_addr_reg != 8'hFF)) begin
                    pm_addr_reg <= pm_addr_reg + 8'd1;
                end
                if (accept) begin
                    if (enc_illegal) begin
                        err_reg <= 1'b1;
                    end else begin
                        pm_we_reg   <= 1'b1;
                        pm_data_reg <= enc_byte;
                        count_reg   <= count_reg + 9'd1;
                        if (count_reg == 9'd255) begin
                            full_reg     <= 1'b1;
                            state_reg    <= ST_FULL;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign in_ready = in_ready_reg;
    assign pm_we    = pm_we_reg;
    assign pm_addr  = pm_addr_reg;
    assign pm_data  = pm_data_reg;
    assign err      = err_reg;
    assign full     = full_reg;
    assign count    = count_reg;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: one-cycle pulse; clears address counter and flags, enters RUN.
REQ-004 SHALL have port in_valid, input, 1: instruction fields valid.
REQ-005 SHALL have port in_ready, output, 1: encoder accepts fields this cycle.
REQ-006 SHALL have port op, input, 3: 0 LOAD, 1 MOV, 2 ALU, 3 JMP, 4 JNZ, 5 NOP; 6-7 illegal.
REQ-007 SHALL have port dst, input, 3: destination code 0-7 (x0,x1,y0,y1,o_reg,m,i,dm).
REQ-008 SHALL have port src, input, 3: MOV source code 0-7.
REQ-009 SHALL have port src_pins, input, 1: MOV source is i_pins.
REQ-010 SHALL have port imm, input, 4: LOAD data or jump target nibble.
REQ-011 SHALL have ports alu_x and alu_y, input, 1 each; alu_func, input, 3.
REQ-012 SHALL have port pm_we, output, 1: program-memory write strobe.
REQ-013 SHALL have port pm_addr, output, 8: write address.
REQ-014 SHALL have port pm_data, output, 8: encoded instruction byte.
REQ-015 SHALL have port err, output, 1: sticky illegal-request flag.
REQ-016 SHALL have port full, output, 1: address 255 has been written.
REQ-017 SHALL have port count, output, 9: bytes written since start (0-256).

Function
REQ-018 SHALL implement FSM IDLE -> RUN on start; RUN -> FULL after write to address 255; FULL -> RUN on start; IDLE/RUN/FULL -> RUN on start.
REQ-019 SHALL drive in_ready = 1 only in RUN.
REQ-020 SHALL accept a request when in_valid && in_ready; accepted request at edge t produces pm_we=1 for exactly the cycle following t (latency 1), pm_data/pm_addr registered.
REQ-021 SHALL encode LOAD as {0, dst, imm}.
REQ-022 SHALL encode MOV with src_pins=0 as {10, dst, src}; dst==src with src_pins=0 is illegal, except dst=src=4 (o_reg <- r) which encodes 8'hA4.
REQ-023 SHALL encode MOV with src_pins=1 as {10, dst, dst}; dst=4 with src_pins=1 is illegal.
REQ-024 SHALL encode ALU as {110, alu_x, alu_y, alu_func}; all 32 combinations legal except the four reserved NOP bytes C8, CF, D8, DF, which are illegal via ALU.
REQ-025 SHALL encode JMP as {1110, imm}, JNZ as {1111, imm}, NOP as 8'hC8.
REQ-026 SHALL, on an illegal request (op 6-7, REQ-022/023/024 cases), consume it, set err, assert no pm_we, and not advance pm_addr/count.
REQ-027 SHALL increment pm_addr after each write; count increments by 1 per write.
REQ-028 SHALL, on write to address 255, set full, set count=256, enter FULL; pm_addr holds 255 (no wrap).
REQ-029 SHALL give start priority over a simultaneous accepted request: request dropped, pm_we=0 next cycle, pm_addr=0, count=0, err=0, full=0.
REQ-030 SHALL ignore in_valid outside RUN.

Reset
REQ-031 SHALL, while reset_n=0, force state IDLE, in_ready=0, pm_we=0, pm_addr=0, pm_data=0, err=0, full=0, count=0.
REQ-032 SHALL, on reset mid-operation, discard any pending write (no pm_we after reset release until a new accepted request).

Structure
REQ-033 SHALL take op codes, destination codes, NOP byte values, and opcode prefixes (LOAD 0, MOV 10, ALU 110, JMP 1110, JNZ 1111) from a shared package used by the decoder bench.
REQ-034 SHALL contain one sub-module, instr_encode_comb: purely combinational fields -> {byte, illegal}; FSM, counters and output registers in instr_encoder.

Verification
REQ-035 SHALL cover: reset, start, LOAD dst=2 imm=9 -> next cycle pm_we=1, pm_addr=0, pm_data=8'h29, count=1.
REQ-036 SHALL cover: MOV dst=4 src=4 -> 8'hA4; MOV dst=1 src_pins=1 -> 8'h89; MOV dst=3 src=3 src_pins=0 -> err=1, no pm_we, pm_addr unchanged.
REQ-037 SHALL cover: ALU x=1 y=0 func=5 -> 8'hD5; ALU x=0 y=1 func=0 (C8) -> err=1; NOP -> 8'hC8; JNZ imm=3 -> 8'hF3.
REQ-038 SHALL cover: 256 back-to-back LOADs -> last pm_addr=255, full=1, count=256, in_ready=0; 257th in_valid ignored.
REQ-039 SHALL cover: start asserted with in_valid in same cycle at pm_addr=7 -> no pm_we, pm_addr=0, count=0, err cleared.
REQ-040 SHALL cover: reset_n low asynchronously between accept edge and write cycle -> pm_we never asserted, all outputs at reset values.
